led_matrix_scanner: RTL

Time-multiplexed driver for the Snake Game Arcade 6x6 LED matrix, directly downstream of the game core that produces the 36-bit LED image. Accepts complete frames through a valid/ready handshake, holds one pending frame in a shadow buffer, and swaps it into the display buffer only at a frame boundary so a frame never tears. Scans one row at a time, with a configurable dwell period and a blanking gap between rows to suppress ghosting.

---
 rtl/led_matrix_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed driver for a ROWS x COLS LED matrix. New frames land in a
// shadow buffer and are swapped into the display buffer only at frame boundaries.
module led_matrix_scanner #(
  parameter int unsigned ROWS  = 6,
  parameter int unsigned COLS  = 6,
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 2
) (
  input  logic                 clock,
  input  logic                 restart_n,
  input  logic [ROWS*COLS-1:0] frame,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic                 enable,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 frame_sync,
  output logic [2:0]           db_row
);

  localparam int unsigned FW      = ROWS * COLS;
  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 0) ? 32'd0 : BLANK - 1);
  localparam logic [2:0]    ROW_LAST   = 3'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   active_q, active_d;
  logic [FW-1:0]   pending_q, pending_d;
  logic            pending_full_q, pending_full_d;
  logic            frame_ready_q, frame_ready_d;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [COLS-1:0] cols_q, cols_d;
  logic            frame_sync_q, frame_sync_d;
  logic            swap;

  // Scan sequencing, frame capture/swap, and next-cycle output image.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    cnt_d          = cnt_q + CW'(1);
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    swap           = 1'b0;
    rows_d         = '0;
    cols_d         = '0;
    frame_sync_d   = 1'b0;

    if (frame_valid && frame_ready_q) begin
      pending_d      = frame;
      pending_full_d = 1'b1;
    end

    if (!enable) begin
      state_d = S_IDLE;
      row_d   = '0;
      cnt_d   = '0;
      swap    = (state_q == S_IDLE) && pending_full_q;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          row_d   = '0;
          cnt_d   = '0;
          swap    = pending_full_q;
          state_d = (BLANK == 0) ? S_DRIVE : S_BLANK;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = (BLANK == 0) ? S_DRIVE : S_BLANK;
            if (row_q == ROW_LAST) begin
              row_d = '0;
              swap  = pending_full_q;
            end else begin
              row_d = row_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Capture and swap never coincide: capture needs an empty shadow, swap a full one.
    if (swap) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    frame_ready_d = !pending_full_d;

    if (state_d == S_DRIVE) begin
      rows_d       = ROWS'(1) << row_d;
      cols_d       = active_d[int'(row_d)*COLS +: COLS];
      frame_sync_d = (row_d == '0) && (cnt_d == '0);
    end
  end

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      frame_ready_q  <= 1'b1;
      rows_q         <= '0;
      cols_q         <= '0;
      frame_sync_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      frame_ready_q  <= frame_ready_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      frame_sync_q   <= frame_sync_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign rows        = rows_q;
  assign cols        = cols_q;
  assign frame_sync  = frame_sync_q;
  assign db_row      = row_q;

endmodule
